// File: rtl/psum_writeback.sv
// psum_writeback: accumulates PE-cluster psum words into a local flop array and drains them requantized.
// Ports: clk/nrst; in_* psum stream (no backpressure); ctrl_* FSM pulses and drain config;
//        out_* valid/ready stream to the GLB; flag_* busy / drain-done pulse / sticky error.
module psum_writeback #(
  parameter int numLanes = 3,
  parameter int inSize   = 20,
  parameter int accSize  = 24,
  parameter int depth    = 32,
  parameter int addrSize = 16,
  parameter int outSize  = 8
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic [numLanes*inSize-1:0]   in_data_i,
  input  logic [addrSize-1:0]          in_addr_i,
  input  logic                         in_valid_i,
  input  logic                         ctrl_clear_i,
  input  logic                         ctrl_accum_i,
  input  logic                         ctrl_pass_done_i,
  input  logic                         ctrl_drain_i,
  input  logic [addrSize-1:0]          ctrl_drain_len_i,
  input  logic [4:0]                   ctrl_shift_i,
  input  logic                         ctrl_relu_i,
  output logic [numLanes*outSize-1:0]  out_data_o,
  output logic [addrSize-1:0]          out_addr_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic                         flag_busy_o,
  output logic                         flag_drain_done_o,
  output logic                         flag_err_o
);

  localparam int idxSize = (depth > 1) ? $clog2(depth) : 1;
  localparam int tW      = accSize + 33;  // headroom for a rounding constant up to 2^30
  localparam logic [addrSize-1:0] depthA  = addrSize'(depth);
  localparam logic [idxSize-1:0]  lastIdx = idxSize'(depth - 1);
  localparam logic signed [tW-1:0] oMax = tW'((1 <<< (outSize - 1)) - 1);
  localparam logic signed [tW-1:0] oMin = tW'(-(1 <<< (outSize - 1)));

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t state_q, state_d;
  logic signed [accSize-1:0] acc_q [depth][numLanes];
  logic [depth-1:0] ent_vld_q;
  logic [idxSize-1:0] ptr_q, ptr_d, last_q, last_d, rd_idx;
  logic len_zero_q, len_zero_d, relu_q, relu_d, done_q, done_d, err_q, err_d, clr;
  logic [4:0] shift_q, shift_d;
  logic out_valid_q, out_valid_d;
  logic [numLanes*outSize-1:0] out_data_q, out_data_d, rd_word;
  logic [addrSize-1:0] out_addr_q, out_addr_d;

  logic addr_ok, wr_en;
  logic [idxSize-1:0] wr_idx;
  logic signed [accSize-1:0] wr_val [numLanes];

  function automatic logic signed [accSize-1:0] add_sat(input logic signed [accSize-1:0] a,
                                                        input logic signed [inSize-1:0]  b);
    logic signed [accSize:0] sum;
    sum = (accSize+1)'(a) + (accSize+1)'(b);
    // Overflow shows up as the two top bits of the widened sum disagreeing.
    if (sum[accSize] != sum[accSize-1])
      return sum[accSize] ? {1'b1, {(accSize-1){1'b0}}} : {1'b0, {(accSize-1){1'b1}}};
    return sum[accSize-1:0];
  endfunction

  function automatic logic [outSize-1:0] requant(input logic signed [accSize-1:0] a,
                                                 input logic [4:0] s, input logic relu);
    logic signed [tW-1:0] t;
    t = tW'(a);
    if (s != 5'd0) t = t + (tW'(1) <<< (s - 5'd1));  // round half up
    t = t >>> s;
    if (relu && (t < 0)) t = '0;
    if (t > oMax) return oMax[outSize-1:0];
    if (t < oMin) return oMin[outSize-1:0];
    return t[outSize-1:0];
  endfunction

  // Accumulate path: reads the flop array combinationally so back-to-back hits on one address chain.
  assign addr_ok = (in_addr_i < depthA);
  assign wr_en   = (state_q == ACCUM) && in_valid_i && addr_ok;
  assign wr_idx  = in_addr_i[idxSize-1:0];

  always_comb begin
    for (int l = 0; l < numLanes; l++) begin
      wr_val[l] = add_sat(ent_vld_q[wr_idx] ? acc_q[wr_idx][l] : '0,
                          in_data_i[l*inSize +: inSize]);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < numLanes; l++) acc_q[wr_idx][l] <= wr_val[l];
    end
  end

  // Drain read: while a word is presented the next one is precomputed so a handshake
  // loads it straight into the output register.
  always_comb begin
    rd_idx  = out_valid_q ? (ptr_q + idxSize'(1)) : ptr_q;
    rd_word = '0;
    for (int l = 0; l < numLanes; l++) begin
      rd_word[l*outSize +: outSize] = requant(ent_vld_q[rd_idx] ? acc_q[rd_idx][l] : '0,
                                              shift_q, relu_q);
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    last_d      = last_q;
    len_zero_d  = len_zero_q;
    shift_d     = shift_q;
    relu_d      = relu_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    done_d      = 1'b0;
    err_d       = err_q;
    clr         = 1'b0;

    if (in_valid_i && ((state_q != ACCUM) || !addr_ok)) err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (ctrl_clear_i) begin
          clr   = 1'b1;
          err_d = 1'b0;
        end else if (ctrl_drain_i) begin
          state_d    = DRAIN;
          ptr_d      = '0;
          len_zero_d = (ctrl_drain_len_i == '0);
          last_d     = (ctrl_drain_len_i > depthA) ? lastIdx
                                                   : idxSize'(ctrl_drain_len_i - addrSize'(1));
          shift_d    = ctrl_shift_i;
          relu_d     = ctrl_relu_i;
        end else if (ctrl_accum_i) begin
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (ctrl_pass_done_i) state_d = IDLE;
      end
      DRAIN: begin
        if (len_zero_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = rd_word;
          out_addr_d  = addrSize'(rd_idx);
        end else if (out_ready_i) begin
          if (ptr_q == last_q) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end else begin
            ptr_d      = ptr_q + idxSize'(1);
            out_data_d = rd_word;
            out_addr_d = addrSize'(rd_idx);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      ent_vld_q   <= '0;
      ptr_q       <= '0;
      last_q      <= '0;
      len_zero_q  <= 1'b0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      last_q      <= last_d;
      len_zero_q  <= len_zero_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      done_q      <= done_d;
      err_q       <= err_d;
      if (clr)        ent_vld_q         <= '0;
      else if (wr_en) ent_vld_q[wr_idx] <= 1'b1;
    end
  end

  assign out_data_o        = out_data_q;
  assign out_addr_o        = out_addr_q;
  assign out_valid_o       = out_valid_q;
  assign flag_busy_o       = (state_q != IDLE);
  assign flag_drain_done_o = done_q;
  assign flag_err_o        = err_q;

endmodule
